// File: rtl/mvm_ctrl_pkg.sv
// Shared state encoding and width helper for the mvm_ctrl layer sequencer.
package mvm_ctrl_pkg;

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        DRAIN,
        OUT
    } state_e;

    // Wide enough to count DRAIN cycles for any latency up to 8.
    localparam int WAIT_W = 4;

    function automatic int widthOf(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mvm_ctrl_delay.sv
// LAT-stage shift register with synchronous active-low clear; LAT==0 is a wire.
module ctrl_delay #(
    parameter int LAT = 1,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    generate
        if (LAT == 0) begin : g_pass
            logic unusedPins;
            assign unusedPins = clk ^ reset;
            assign q_o = d_i;
        end else begin : g_shift
            logic [W-1:0] stage_q [LAT];

            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign q_o = stage_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/mvm_ctrl.sv
// Sequencer for one y = W*x layer with P MAC lanes sharing x-memory and weight ROM.
// Define MVM_CTRL_OVERLAP_EN to load the next vector during the final output group.
module mvm_ctrl
    import mvm_ctrl_pkg::*;
#(
    parameter int M   = 8,
    parameter int N   = 8,
    parameter int P   = 2,
    parameter int LAT = 1,
    localparam int XW = widthOf(N),
    localparam int WW = widthOf(M / P * N),
    localparam int SW = widthOf(P)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid_x,
    output logic          s_ready_x,
    output logic          x_we,
    output logic [XW-1:0] x_waddr,
    output logic [XW-1:0] x_raddr,
    output logic [WW-1:0] w_addr,
    output logic          acc_clr,
    output logic          acc_en,
    output logic [SW-1:0] y_sel,
    output logic          m_valid_y,
    input  logic          m_ready_y
);

    localparam int G  = M / P;
    localparam int LW = widthOf(N + 1);
    localparam int GW = widthOf(G);
    localparam logic [LW-1:0]     LD_FULL   = LW'(N);
    localparam logic [LW-1:0]     LD_LAST   = LW'(N - 1);
    localparam logic [XW-1:0]     K_LAST    = XW'(N - 1);
    localparam logic [GW-1:0]     G_LAST    = GW'(G - 1);
    localparam logic [SW-1:0]     LANE_LAST = SW'(P - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((LAT > 0) ? LAT - 1 : 0);

    state_e             state_q, state_d;
    logic [LW-1:0]      ld_q, ld_d;
    logic [XW-1:0]      k_q, k_d;
    logic [GW-1:0]      g_q, g_d;
    logic [SW-1:0]      lane_q, lane_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               loadReady;
    logic               outValid;
    logic [1:0]         dlyIn;
    logic [1:0]         dlyOut;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= LOAD;
            ld_q    <= '0;
            k_q     <= '0;
            g_q     <= '0;
            lane_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            k_q     <= k_d;
            g_q     <= g_d;
            lane_q  <= lane_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ld_d      = ld_q;
        k_d       = k_q;
        g_d       = g_q;
        lane_d    = lane_q;
        wait_d    = wait_q;
        loadReady = 1'b0;
        outValid  = 1'b0;

        unique case (state_q)
            LOAD: begin
                loadReady = 1'b1;
                if (s_valid_x) begin
                    ld_d = ld_q + 1'b1;
                    if (ld_q == LD_LAST) begin
                        ld_d    = '0;
                        k_d     = '0;
                        g_d     = '0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    wait_d  = '0;
                    state_d = (LAT > 0) ? DRAIN : OUT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = OUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            OUT: begin
                outValid = 1'b1;
`ifdef MVM_CTRL_OVERLAP_EN
                // x-memory is idle in the last OUT, so the next vector may stream in.
                if (g_q == G_LAST && ld_q != LD_FULL) begin
                    loadReady = 1'b1;
                    if (s_valid_x) ld_d = ld_q + 1'b1;
                end
`endif
                if (m_ready_y) begin
                    if (lane_q == LANE_LAST) begin
                        lane_d = '0;
                        if (g_q != G_LAST) begin
                            g_d     = g_q + 1'b1;
                            state_d = ISSUE;
                        end else begin
`ifdef MVM_CTRL_OVERLAP_EN
                            if (ld_d == LD_FULL) begin
                                ld_d    = '0;
                                g_d     = '0;
                                state_d = ISSUE;
                            end else begin
                                state_d = LOAD;
                            end
`else
                            state_d = LOAD;
`endif
                        end
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Issue-valid and first-product flag travel alongside the MAC pipeline.
    assign dlyIn = {state_q == ISSUE, (state_q == ISSUE) && (k_q == '0)};

    ctrl_delay #(
        .LAT (LAT),
        .W   (2)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .d_i   (dlyIn),
        .q_o   (dlyOut)
    );

    assign s_ready_x = loadReady & reset;
    assign x_we      = loadReady & s_valid_x & reset;
    assign x_waddr   = XW'(ld_q);
    assign x_raddr   = k_q;
    assign w_addr    = WW'(int'(g_q) * N + int'(k_q));
    assign acc_en    = dlyOut[1] & reset;
    assign acc_clr   = dlyOut[0] & reset;
    assign y_sel     = lane_q;
    assign m_valid_y = outValid & reset;

endmodule

// File: doc/mvm_ctrl.md
Name: mvm_ctrl

Overview:
- Sequencing controller for one matrix-vector layer: y = W·x, with P parallel MAC lanes sharing one input-vector memory and one weight ROM.
- Accepts N input words on a valid/ready stream and drives the x-memory write port.
- Steps weight/x read addresses over ceil(M/P) row groups and gates the MAC accumulators.
- Emits M outputs on a valid/ready stream by selecting lanes. Sits between the layer's input/output ports and its x-memory, weight ROM and MAC lanes.

Parameters:
- M, 8, output rows; M % P == 0 required.
- N, 8, input vector length; N >= 1.
- P, 2, parallel MAC lanes; P >= 1.
- LAT, 1, cycles from address issue to product valid at accumulator input; 0 <= LAT <= 8.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- s_valid_x  in  1  input word valid.
- s_ready_x  out  1  controller accepts input word.
- x_we  out  1  x-memory write enable (= s_valid_x && s_ready_x).
- x_waddr  out  XW  x-memory write address; XW = max(1, clog2(N)).
- x_raddr  out  XW  x-memory read address.
- w_addr  out  WW  weight ROM address, group*N + k; WW = max(1, clog2(M/P*N)).
- acc_clr  out  1  accumulator loads product instead of adding (first product of a group).
- acc_en  out  1  accumulator update enable.
- y_sel  out  SW  lane driving output data; SW = max(1, clog2(P)).
- m_valid_y  out  1  output word valid.
- m_ready_y  in  1  downstream accepts output.

Behaviour:
- Reset (reset==0 at posedge):
  - state=LOAD; all counters (ld, k, g, lane, wait) = 0; delay line cleared.
  - While reset is low: s_ready_x=0, m_valid_y=0, x_we=0, acc_en=0, acc_clr=0.
  - Mid-operation reset discards partial vector/outputs with no further handshakes; the first accepted word after release is x[0].
- LOAD:
  - s_ready_x=1. On handshake: x_we=1, x_waddr=ld, ld++.
  - The handshake that makes ld==N goes to ISSUE with ld=0, k=0, g=0.
- ISSUE:
  - One address per cycle, no stalls: x_raddr=k, w_addr=g*N+k; k increments.
  - At k==N-1 go to DRAIN (LAT>0) or OUT (LAT==0), with k=0.
  - Issue-valid and first-flag (k==0) pass through an LAT-stage delay line; outputs are acc_en and acc_clr. LAT==0 means a direct connection.
- DRAIN:
  - Wait LAT cycles so the last delayed acc_en has fired, then go to OUT.
- OUT:
  - m_valid_y=1, y_sel=lane. On m_ready_y: lane++.
  - The handshake at lane==P-1 sets lane=0:
    - g<M/P-1: g++, go to ISSUE.
    - otherwise go to LOAD.
  - Output order is row g*P+lane, ascending.
  - m_valid_y stays high without m_ready_y; y_sel is held stable until the handshake.
- s_ready_x=0 outside LOAD (except under the Optional Feature); m_valid_y=0 outside OUT.
- Per-group cycle count with no stalls is N + LAT + P.
- Address/data outputs are don't-care when their enable is low, but must be driven (no X).

Optional Feature:
- Macro: MVM_CTRL_OVERLAP_EN.
- With the macro: during OUT of the last group, s_ready_x=1 and loading of the next vector proceeds via ld (x-memory is no longer read).
  - On leaving the last OUT: ld==N goes to ISSUE (ld=0); otherwise go to LOAD, keeping ld.
  - Simultaneous input and output handshakes in the same cycle are both honoured.
- Without the macro: s_ready_x is strictly LOAD-only, as above.

Decomposition:
- Package mvm_ctrl_pkg: state enum (LOAD, ISSUE, DRAIN, OUT) and a width function returning max(1, clog2(n)).
- Sub-module ctrl_delay: parameterised LAT-stage shift register with synchronous active-low clear, carrying {acc_en, acc_clr}; LAT==0 is a pass-through.

Test Plan:
- M=4, N=3, P=2, LAT=1, ready/valid always 1:
  - x_we on 3 consecutive cycles, addresses 0,1,2.
  - Group 0: w_addr 0,1,2 with acc_en/acc_clr one cycle later, acc_clr only with the first.
  - m_valid_y two cycles with y_sel 0,1; then group 1 w_addr 3,4,5; then LOAD.
- Same config, m_ready_y low 5 cycles in OUT: m_valid_y held, y_sel held at 0, no ISSUE activity; resumes correctly.
- Random s_valid_x/m_ready_y (50%), 100 vectors with golden MAC model fed by the controller outputs: all 400 outputs match; no output before the Nth input of each vector.
- reset low during ISSUE of group 1:
  - The next cycle shows every output at 0.
  - After release, s_ready_x=1 and x_waddr=0.
- LAT=0 and LAT=4 with N=1, P=1, M=2: acc_clr and acc_en coincide on every update; outputs appear exactly LAT+1 cycles after issue.
- MVM_CTRL_OVERLAP_EN defined: next vector's 3 words are accepted during the final OUT; ISSUE starts the cycle after the last output handshake with no LOAD cycles.
